poly_phase_accumulator: RTL and testbench
=========================================

# poly_phase_accumulator

Time-multiplexed, multi-voice phase accumulator for the polyphonic NCO path. One shared adder advances the phases of VOICES independent oscillators, one voice per clock, in a sweep triggered once per audio sample. Each voice has its own tuning word, a hard-sync request and a wrap (carry) flag. Output is a stream of (voice, phase) beats that feeds the shared waveform lookup and mixer.

## Interface
- WORD_BITS, 32: phase and tuning-word width; wraps modulo 2^WORD_BITS.
- VOICES, 8: voice count, ≥2.
- VOICE_BITS, max($clog2(VOICES),1): voice index width (derived, not overridden).

- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  when low, tick_i is ignored; a sweep already in progress completes.
- tick_i  in  1  sample strobe, one-cycle pulse; starts a sweep.
- wr_en_i  in  1  tuning-word write strobe.
- wr_voice_i  in  VOICE_BITS  voice written; values ≥VOICES are dropped.
- wr_data_i  in  WORD_BITS  tuning word (phase increment).
- sync_i  in  VOICES  per-voice hard-sync request pulses.
- valid_o  out  1  output beat valid.
- voice_o  out  VOICE_BITS  voice index of the beat.
- phase_o  out  WORD_BITS  updated phase of that voice.
- wrap_o  out  1  carry out of the phase add for that beat.
- busy_o  out  1  high while a sweep is in progress.
- overrun_o  out  1  one-cycle pulse: tick_i arrived while busy and was dropped.

## Operation
- Storage: phase[VOICES], tune[VOICES], sync_pend[VOICES], all WORD_BITS or 1 bit. Reset clears all of them to 0.
- FSM states:
  - IDLE: tick_i & enable_i → RUN, idx=0.
  - RUN: one voice processed per cycle. idx==VOICES-1 → IDLE. Otherwise idx+1.
- Processing voice v in RUN:
  - Let s = sync_pend[v] | sync_i[v].
  - If s: phase[v] ← 0 and wrap = 0.
  - Else {wrap, phase[v]} ← phase[v] + tune[v] as a (WORD_BITS+1)-bit sum; phase keeps the low WORD_BITS.
  - sync_pend[v] ← 0.
- Sync pulses:
  - sync_i[v] sets sync_pend[v] in any cycle where voice v is not being processed.
  - Multiple pulses before processing collapse into one sync.
- Tuning writes apply in any state.
  - A write to voice v in the same cycle v is processed: the add uses the old tune[v]; the new value applies from the next sweep.
- Tick handling:
  - tick_i while busy: dropped, overrun_o pulses, sweep unaffected.
  - tick_i with enable_i low: ignored silently, no overrun.
- Output order within a sweep is always voice 0 … VOICES-1.

## Timing
- Reset values: valid_o=0, voice_o=0, phase_o=0, wrap_o=0, busy_o=0, overrun_o=0, FSM=IDLE, idx=0.
- Reset asserted mid-sweep aborts immediately. No further beats are produced.
- tick_i sampled at edge T:
  - busy_o=1 from T until the edge that registers the last beat.
  - Voice k is processed in cycle T+k.
  - Its beat is registered at edge T+1+k, so valid_o is high for VOICES consecutive cycles.
- Outputs are registered. voice_o, phase_o and wrap_o are held when valid_o=0.
- busy_o falls at the same edge as the final beat. The next tick is accepted one cycle later, so the minimum tick period is VOICES+1 cycles.
- overrun_o is registered: it pulses the cycle after the dropped tick.
- Throughput: 1 voice/cycle. Latency from tick to the voice k beat is k+1 cycles.

## Test plan
- Reset then single sweep:
  - Stimulus: rst_i, then tune[0..7]=1..8, one tick.
  - Required: 8 valid beats, voice 0..7, phase=1..8, wrap=0. busy_o falls with beat 7. First beat 1 cycle after the tick edge.
- Wrap-around:
  - Stimulus: tune[3]=0xC000_0000, two ticks.
  - Required: voice 3 phase 0xC000_0000 (wrap 0), then 0x8000_0000 (wrap 1).
- Hard sync:
  - Stimulus: tune[2]=0x100, 3 sweeps, then sync_i[2] pulsed twice before the next tick.
  - Required: voice 2 phase 0 with wrap 0 once. The following sweep gives 0x100.
  - Also: sync_i[5] pulsed in the exact cycle voice 5 is processed forces 0 in that sweep only.
- Write/process collision:
  - Stimulus: write tune[4]=0x10 in the cycle voice 4 is processed (old tune 0x1).
  - Required: that beat uses the old increment (+0x1); the next sweep adds 0x10.
- Overrun and enable:
  - Stimulus: tick at sweep cycle 3.
  - Required: overrun_o pulses once, the sweep is unchanged, 8 beats total.
  - Stimulus: tick with enable_i=0.
  - Required: no beats, no overrun.
  - Stimulus: enable_i dropped mid-sweep.
  - Required: the sweep completes.
- Reset mid-sweep:
  - Stimulus: rst_i asserted after beat 2.
  - Required: all outputs 0 immediately. The next tick yields phase = tune (all phases were cleared), with tune words 0 after reset.

Source files
------------

// File: rtl/poly_phase_accumulator.sv
// poly_phase_accumulator: time-multiplexed multi-voice NCO phase accumulator, one voice per clock
module poly_phase_accumulator #(
  parameter int WORD_BITS = 32,
  parameter int VOICES = 8,
  localparam int VOICE_BITS = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  tick_i,
  input  logic                  wr_en_i,
  input  logic [VOICE_BITS-1:0] wr_voice_i,
  input  logic [WORD_BITS-1:0]  wr_data_i,
  input  logic [VOICES-1:0]     sync_i,
  output logic                  valid_o,
  output logic [VOICE_BITS-1:0] voice_o,
  output logic [WORD_BITS-1:0]  phase_o,
  output logic                  wrap_o,
  output logic                  busy_o,
  output logic                  overrun_o
);
  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t                r_state, w_next;
  logic [VOICE_BITS-1:0] r_idx;
  logic [WORD_BITS-1:0]  r_phase [VOICES];
  logic [WORD_BITS-1:0]  r_tune [VOICES];
  logic [VOICES-1:0]     r_sync_pend;
  logic                  r_valid, r_wrap, r_overrun;
  logic [VOICE_BITS-1:0] r_voice;
  logic [WORD_BITS-1:0]  r_phase_out;
  logic                  w_run, w_last, w_start, w_sync, w_wr_ok;
  logic [WORD_BITS:0]    w_sum;
  logic [VOICES-1:0]     w_proc;

  assign w_last  = r_idx == VOICE_BITS'(VOICES - 1);
  assign w_start = tick_i & enable_i & ~w_run;
  assign w_sync  = r_sync_pend[r_idx] | sync_i[r_idx];
  assign w_sum   = {1'b0, r_phase[r_idx]} + {1'b0, r_tune[r_idx]};
  assign w_wr_ok = wr_en_i && (32'(wr_voice_i) < VOICES);
  assign w_proc  = w_run ? (VOICES'(1) << r_idx) : '0;

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= S_IDLE;
    else r_state <= w_next;

  // FSM next state: a sweep runs until the last voice has been processed
  always_comb
    w_next = w_run ? (w_last ? S_IDLE : S_RUN) : (w_start ? S_RUN : S_IDLE);

  // FSM outputs: busy spans exactly the cycles in which a voice is processed
  always_comb begin
    w_run  = r_state == S_RUN;
    busy_o = w_run;
  end

  // voice index walks 0..VOICES-1 during a sweep and rests at 0 otherwise
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_idx <= '0;
    else if (w_run) r_idx <= w_last ? '0 : r_idx + 1'b1;
    else r_idx <= '0;

  // shared adder writes back the processed voice; sync forces the phase to zero
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int v = 0; v < VOICES; v++) r_phase[v] <= '0;
    end else if (w_run) begin
      r_phase[r_idx] <= w_sync ? '0 : w_sum[WORD_BITS-1:0];
    end

  // tuning words are read by the adder before this write lands, so a colliding write takes effect next sweep
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int v = 0; v < VOICES; v++) r_tune[v] <= '0;
    end else if (w_wr_ok) begin
      r_tune[wr_voice_i] <= wr_data_i;
    end

  // pending syncs collect pulses for idle voices and are consumed when the voice is processed
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_sync_pend <= '0;
    else r_sync_pend <= (r_sync_pend | sync_i) & ~w_proc;

  // registered beat outputs; data holds between beats
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_voice     <= '0;
      r_phase_out <= '0;
      r_wrap      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_valid   <= w_run;
      r_overrun <= tick_i & enable_i & w_run;
      if (w_run) begin
        r_voice     <= r_idx;
        r_phase_out <= w_sync ? '0 : w_sum[WORD_BITS-1:0];
        r_wrap      <= ~w_sync & w_sum[WORD_BITS];
      end
    end

  assign valid_o   = r_valid;
  assign voice_o   = r_voice;
  assign phase_o   = r_phase_out;
  assign wrap_o    = r_wrap;
  assign overrun_o = r_overrun;
endmodule

// File: tb/tb_poly_phase_accumulator.sv
// tb_poly_phase_accumulator: directed and random checks of the voice sweep against a reference model
module tb_poly_phase_accumulator;
  localparam int V = 8;
  logic        clk_i = 0, rst_i = 1, enable_i = 0, tick_i = 0, wr_en_i = 0;
  logic [2:0]  wr_voice_i = 0;
  logic [31:0] wr_data_i = 0;
  logic [V-1:0] sync_i = 0;
  logic        valid_o, wrap_o, busy_o, overrun_o;
  logic [2:0]  voice_o;
  logic [31:0] phase_o;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] m_phase [V];
  logic [31:0] m_tune [V];
  logic [V-1:0] m_pend;
  int          m_pos;
  logic        e_valid, e_wrap, e_over;
  int          e_voice;
  logic [31:0] e_phase;

  poly_phase_accumulator dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .tick_i(tick_i),
    .wr_en_i(wr_en_i), .wr_voice_i(wr_voice_i), .wr_data_i(wr_data_i), .sync_i(sync_i),
    .valid_o(valid_o), .voice_o(voice_o), .phase_o(phase_o), .wrap_o(wrap_o),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(valid_o), 32'(e_valid));
    chk("voice", 32'(voice_o), 32'(e_voice));
    chk("phase", phase_o, e_phase);
    chk("wrap", 32'(wrap_o), 32'(e_wrap));
    chk("busy", 32'(busy_o), 32'(m_pos >= 0));
    chk("overrun", 32'(overrun_o), 32'(e_over));
  endtask

  task automatic model_clear();
    for (int u = 0; u < V; u++) begin
      m_phase[u] = 0;
      m_tune[u] = 0;
    end
    m_pend = 0; m_pos = -1;
    e_valid = 0; e_voice = 0; e_phase = 0; e_wrap = 0; e_over = 0;
  endtask

  task automatic do_reset();
    rst_i = 1;
    #1;
    model_clear();
    check_all();
    @(posedge clk_i); #1;
    rst_i = 0;
  endtask

  task automatic step(input bit tk, input bit en, input bit we, input int wv,
                      input logic [31:0] wd, input logic [V-1:0] sy);
    logic [32:0] sum;
    tick_i = tk; enable_i = en; wr_en_i = we; wr_voice_i = 3'(wv); wr_data_i = wd; sync_i = sy;
    e_over = tk && en && m_pos >= 0;
    e_valid = 0;
    if (m_pos >= 0) begin
      sum = {1'b0, m_phase[m_pos]} + {1'b0, m_tune[m_pos]};
      if (m_pend[m_pos] || sy[m_pos]) sum = 0;
      {e_wrap, e_phase} = sum;
      m_phase[m_pos] = e_phase;
      e_valid = 1; e_voice = m_pos;
    end
    for (int u = 0; u < V; u++) m_pend[u] = (u == m_pos) ? 1'b0 : (m_pend[u] | sy[u]);
    if (we) m_tune[wv] = wd;
    m_pos = (m_pos >= 0) ? ((m_pos == V - 1) ? -1 : m_pos + 1) : ((tk && en) ? 0 : -1);
    @(posedge clk_i); #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
  endtask

  task automatic wr(input int v, input logic [31:0] d);
    step(0, 1, 1, v, d, 0);
  endtask

  // one full sweep: optional sync / write aimed at the processing cycle of a voice,
  // optional overrun tick at sweep cycle ov_k, enable dropped from cycle en_k on
  task automatic sweep(input int sy_v, input int wr_v, input logic [31:0] wr_d, input int ov_k, input int en_k);
    step(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < V; k++)
      step(k == ov_k, k < en_k, k == wr_v, k, wr_d, (k == sy_v) ? V'(1 << k) : V'(0));
    idle(1);
  endtask

  initial begin
    do_reset();
    do_reset();
    for (int v = 0; v < V; v++) wr(v, 32'(v + 1));
    sweep(-1, -1, 0, 99, 99);
    wr(3, 32'hC000_0000);
    sweep(-1, -1, 0, 99, 99);
    sweep(-1, -1, 0, 99, 99);
    wr(2, 32'h100);
    for (int i = 0; i < 3; i++) sweep(-1, -1, 0, 99, 99);
    step(0, 1, 0, 0, 0, 8'h04);
    idle(2);
    step(0, 1, 0, 0, 0, 8'h04);
    sweep(-1, -1, 0, 99, 99);
    sweep(-1, -1, 0, 99, 99);
    sweep(5, -1, 0, 99, 99);
    sweep(-1, -1, 0, 99, 99);
    wr(4, 32'h1);
    sweep(-1, -1, 0, 99, 99);
    sweep(-1, 4, 32'h10, 99, 99);
    sweep(-1, -1, 0, 99, 99);
    sweep(-1, -1, 0, 3, 99);
    sweep(-1, -1, 0, 7, 99);
    step(1, 0, 0, 0, 0, 0);
    idle(3);
    sweep(-1, -1, 0, 99, 4);
    step(1, 1, 0, 0, 0, 0);
    idle(3);
    do_reset();
    sweep(-1, -1, 0, 99, 99);
    wr(0, 32'h1234_5678);
    wr(7, 32'hFFFF_FFFF);
    sweep(-1, -1, 0, 99, 99);
    sweep(-1, -1, 0, 99, 99);
    for (int i = 0; i < 600; i++)
      step($urandom_range(5) == 0, $urandom_range(7) != 0, $urandom_range(3) == 0,
           $urandom_range(V - 1), ($urandom_range(1) == 0) ? 32'($urandom) : 32'hF000_0000 | 32'($urandom_range(255)),
           ($urandom_range(4) == 0) ? V'($urandom) & V'($urandom) : V'(0));
    idle(V + 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
